// File: rtl/binary_counter_n.sv
// Parametrised up/down binary counter with programmable modulus, wrap or saturate
// overflow handling, a one-cycle terminal-count pulse and a sticky overflow flag.
module binary_counter_n #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] load_value;
  logic             at_max;
  logic             at_min;

  // Values above MAX are clamped on load rather than flagged.
  assign load_value = (in > MAX) ? MAX : in;
  assign at_max     = (out == MAX);
  assign at_min     = (out == '0);
  assign zero       = at_min;

  // NOTE: every register here uses <= so all of them sample the pre-edge count;
  // blocking assignments would let tc/ovf see the already-updated out.
  always_ff @(posedge clock) begin
    if (rst) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (clear) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      out <= load_value;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (inc && !dec) begin
      if (!at_max) begin
        out <= out + 1'b1;
        tc  <= 1'b0;
      end else begin
        // Explicit compare against MAX: the wrap must not depend on natural overflow.
        tc <= 1'b1;
        if (SATURATE) ovf <= 1'b1;
        else          out <= '0;
      end
    end else if (dec && !inc) begin
      if (!at_min) begin
        out <= out - 1'b1;
        tc  <= 1'b0;
      end else begin
        tc <= 1'b1;
        if (SATURATE) ovf <= 1'b1;
        else          out <= MAX;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_counter_n.sv
// Directed bench for binary_counter_n: a 4-bit modulo-10 wrap instance, a 4-bit
// modulo-10 saturating instance and a default 16-bit instance share one clock.
module tb_binary_counter_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=4, MAX=9, wrap
  logic       a_rst, a_load, a_inc, a_dec, a_clear;
  logic [3:0] a_in, a_out;
  logic       a_tc, a_zero, a_ovf;
  // Instance B: WIDTH=4, MAX=9, saturate
  logic       b_rst, b_load, b_inc, b_dec, b_clear;
  logic [3:0] b_in, b_out;
  logic       b_tc, b_zero, b_ovf;
  // Instance C: WIDTH=16 defaults
  logic        c_rst, c_load, c_inc, c_dec, c_clear;
  logic [15:0] c_in, c_out;
  logic        c_tc, c_zero, c_ovf;

  binary_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) u_a (
    .clock(clock), .rst(a_rst), .in(a_in), .load(a_load), .inc(a_inc), .dec(a_dec),
    .clear(a_clear), .out(a_out), .tc(a_tc), .zero(a_zero), .ovf(a_ovf)
  );

  binary_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) u_b (
    .clock(clock), .rst(b_rst), .in(b_in), .load(b_load), .inc(b_inc), .dec(b_dec),
    .clear(b_clear), .out(b_out), .tc(b_tc), .zero(b_zero), .ovf(b_ovf)
  );

  binary_counter_n u_c (
    .clock(clock), .rst(c_rst), .in(c_in), .load(c_load), .inc(c_inc), .dec(c_dec),
    .clear(c_clear), .out(c_out), .tc(c_tc), .zero(c_zero), .ovf(c_ovf)
  );

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_in = 4'd5; b_in = 4'd5; c_in = 16'h1234;
    a_load = 1; b_load = 1; c_load = 1;
    a_inc = 0; a_dec = 0; a_clear = 0;
    b_inc = 0; b_dec = 0; b_clear = 0;
    c_inc = 0; c_dec = 0; c_clear = 0;
    tick();
    a_rst = 0; b_rst = 0; c_rst = 0;
    a_load = 0; b_load = 0; c_load = 0;
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got out=%0d tc=%b zero=%b ovf=%b, want out=0 tc=0 zero=1 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    checks++;
    if ({b_out, b_tc, b_zero, b_ovf} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got out=%0d tc=%b zero=%b ovf=%b, want out=0 tc=0 zero=1 ovf=0",
               b_out, b_tc, b_zero, b_ovf);
    end
    checks++;
    if ({c_out, c_tc, c_zero, c_ovf} !== {16'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_c: got out=%0h tc=%b zero=%b ovf=%b, want out=0 tc=0 zero=1 ovf=0",
               c_out, c_tc, c_zero, c_ovf);
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] up_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                4'd0, 4'd1, 4'd2};
    logic [3:0] eo;
    a_in  = 'x;  // in must not leak into the count while load is low
    a_inc = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      eo = up_seq[i];
      checks++;
      if ({a_out, a_tc, a_zero, a_ovf} !== {eo, eo == 4'd0, eo == 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got out=%0d tc=%b zero=%b ovf=%b, want out=%0d tc=%b zero=%b ovf=0",
                 i, a_out, a_tc, a_zero, a_ovf, eo, eo == 4'd0, eo == 4'd0);
      end
    end
    a_inc = 0;
    a_in  = 4'd0;
  endtask

  task automatic test_wrap_down();
    logic [3:0] down_seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    logic [3:0] eo;
    a_in = 4'd3; a_load = 1;
    tick();
    a_load = 0;
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd3, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load3: got out=%0d tc=%b zero=%b ovf=%b, want out=3 tc=0 zero=0 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    a_dec = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      eo = down_seq[i];
      checks++;
      if ({a_out, a_tc, a_zero, a_ovf} !== {eo, eo == 4'd9, eo == 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL wrap_down[%0d]: got out=%0d tc=%b zero=%b ovf=%b, want out=%0d tc=%b zero=%b ovf=0",
                 i, a_out, a_tc, a_zero, a_ovf, eo, eo == 4'd9, eo == 4'd0);
      end
    end
    a_dec = 0;
  endtask

  task automatic test_back_to_back();
    a_in = 4'd9; a_load = 1;
    tick();
    a_load = 0; a_inc = 1;
    tick();
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_up: got out=%0d tc=%b zero=%b ovf=%b, want out=0 tc=1 zero=1 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    a_inc = 0; a_dec = 1;
    tick();
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd9, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_down: got out=%0d tc=%b zero=%b ovf=%b, want out=9 tc=1 zero=0 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    tick();
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd8, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_after: got out=%0d tc=%b zero=%b ovf=%b, want out=8 tc=0 zero=0 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    a_dec = 0;
  endtask

  task automatic test_priority();
    a_in = 4'd5; a_load = 1;
    tick();
    a_in = 4'd7; a_clear = 1; a_inc = 1;  // load still high
    tick();
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL prio_clear: got out=%0d tc=%b zero=%b ovf=%b, want out=0 tc=0 zero=1 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    a_clear = 0;
    tick();
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd7, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_load: got out=%0d tc=%b zero=%b ovf=%b, want out=7 tc=0 zero=0 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    a_load = 0; a_dec = 1;  // inc and dec both high
    tick();
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd7, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_incdec: got out=%0d tc=%b zero=%b ovf=%b, want out=7 tc=0 zero=0 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
    a_inc = 0; a_dec = 0;
  endtask

  task automatic test_load_clamp();
    a_in = 4'd14; a_load = 1;
    tick();
    a_load = 0;
    checks++;
    if ({a_out, a_tc, a_zero, a_ovf} !== {4'd9, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clamp_a: got out=%0d tc=%b zero=%b ovf=%b, want out=9 tc=0 zero=0 ovf=0",
               a_out, a_tc, a_zero, a_ovf);
    end
  endtask

  task automatic test_saturate();
    logic exp_flag [3] = '{1'b0, 1'b1, 1'b1};
    b_in = 4'd8; b_load = 1;
    tick();
    b_load = 0; b_inc = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({b_out, b_tc, b_zero, b_ovf} !== {4'd9, exp_flag[i], 1'b0, exp_flag[i]}) begin
        errors++;
        $display("FAIL sat_up[%0d]: got out=%0d tc=%b zero=%b ovf=%b, want out=9 tc=%b zero=0 ovf=%b",
                 i, b_out, b_tc, b_zero, b_ovf, exp_flag[i], exp_flag[i]);
      end
    end
    b_inc = 0;
    tick();
    checks++;
    if ({b_out, b_tc, b_zero, b_ovf} !== {4'd9, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_sticky: got out=%0d tc=%b zero=%b ovf=%b, want out=9 tc=0 zero=0 ovf=1",
               b_out, b_tc, b_zero, b_ovf);
    end
    b_in = 4'd2; b_load = 1;
    tick();
    checks++;
    if ({b_out, b_tc, b_zero, b_ovf} !== {4'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sat_load2: got out=%0d tc=%b zero=%b ovf=%b, want out=2 tc=0 zero=0 ovf=0",
               b_out, b_tc, b_zero, b_ovf);
    end
    b_in = 4'd0;
    tick();
    b_load = 0; b_dec = 1;
    tick();
    checks++;
    if ({b_out, b_tc, b_zero, b_ovf} !== {4'd0, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sat_under: got out=%0d tc=%b zero=%b ovf=%b, want out=0 tc=1 zero=1 ovf=1",
               b_out, b_tc, b_zero, b_ovf);
    end
    b_dec = 0; b_in = 4'd14; b_load = 1;
    tick();
    checks++;
    if ({b_out, b_tc, b_zero, b_ovf} !== {4'd9, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clamp_b: got out=%0d tc=%b zero=%b ovf=%b, want out=9 tc=0 zero=0 ovf=0",
               b_out, b_tc, b_zero, b_ovf);
    end
    b_load = 0; b_inc = 1;
    tick();
    b_inc = 0; b_clear = 1;
    tick();
    b_clear = 0;
    checks++;
    if ({b_out, b_tc, b_zero, b_ovf} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sat_clear: got out=%0d tc=%b zero=%b ovf=%b, want out=0 tc=0 zero=1 ovf=0",
               b_out, b_tc, b_zero, b_ovf);
    end
  endtask

  task automatic test_mid_reset();
    c_in = 16'hFFFD; c_load = 1;
    tick();
    c_load = 0; c_inc = 1;
    tick();
    checks++;
    if ({c_out, c_tc, c_zero, c_ovf} !== {16'hFFFE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_count: got out=%0h tc=%b zero=%b ovf=%b, want out=fffe tc=0 zero=0 ovf=0",
               c_out, c_tc, c_zero, c_ovf);
    end
    c_rst = 1;
    tick();
    checks++;
    if ({c_out, c_tc, c_zero, c_ovf} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got out=%0h tc=%b zero=%b ovf=%b, want out=0 tc=0 zero=1 ovf=0",
               c_out, c_tc, c_zero, c_ovf);
    end
    c_rst = 0;
    tick();
    checks++;
    if ({c_out, c_tc, c_zero, c_ovf} !== {16'h0001, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset: got out=%0h tc=%b zero=%b ovf=%b, want out=1 tc=0 zero=0 ovf=0",
               c_out, c_tc, c_zero, c_ovf);
    end
    c_inc = 0; c_in = 16'hFFFF; c_load = 1;
    tick();
    c_load = 0; c_inc = 1;
    tick();
    c_inc = 0;
    checks++;
    if ({c_out, c_tc, c_zero, c_ovf} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap16: got out=%0h tc=%b zero=%b ovf=%b, want out=0 tc=1 zero=1 ovf=0",
               c_out, c_tc, c_zero, c_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_back_to_back();
    test_priority();
    test_load_clamp();
    test_saturate();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
